// File: rtl/vpu_pkg.sv
// vpu_pkg: shared VPU widths and result-buffer defaults.
package vpu_pkg;
    localparam int OPERAND_WIDTH = 16;
    localparam int RESBUF_DEPTH = 8;
    localparam int RESBUF_CNT_W = $clog2(RESBUF_DEPTH + 1);
    typedef logic [RESBUF_CNT_W-1:0] resbuf_cnt_t;
endpackage

// File: rtl/vpu_resbuf_fifo.sv
// vpu_resbuf_fifo: result storage with pointers, occupancy and flush.
module vpu_resbuf_fifo
    import vpu_pkg::*;
#(
    parameter int DEPTH = RESBUF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [OPERAND_WIDTH-1:0] wdata_i,
    output logic [OPERAND_WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [OPERAND_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic written_q, written_d;
    logic do_push, do_pop;
    always_comb begin
        full_o    = count_q == CNT_W'(DEPTH);
        do_pop    = pop_i && count_q != '0;
        do_push   = push_i && !flush_i && (!full_o || do_pop);
        wr_d      = flush_i ? '0 : wr_q + PTR_W'(do_push);
        rd_d      = flush_i ? '0 : rd_q + PTR_W'(do_pop);
        count_d   = flush_i ? '0 : count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        written_d = written_q | do_push;
        // Storage is unreset, so the head reads zero until something has been written.
        rdata_o   = written_q ? mem_q[rd_q] : '0;
        count_o   = count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            written_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            written_q <= written_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/vpu_fp_result_buffer.sv
// vpu_fp_result_buffer: credit-gated capture of exp results with valid/ready output.
// Optional same-cycle bypass of an empty buffer: VPU_FP_RESBUF_BYPASS_EN.
module vpu_fp_result_buffer
    import vpu_pkg::*;
#(
    parameter int DEPTH = RESBUF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_req_i,
    output logic                     issue_ready_o,
    output logic                     issue_o,
    input  logic                     done_i,
    input  logic [OPERAND_WIDTH-1:0] result_i,
    output logic                     valid_o,
    output logic [OPERAND_WIDTH-1:0] data_o,
    input  logic                     ready_i,
    input  logic                     flush_i,
    output logic [CNT_W-1:0]         count_o,
    output logic [CNT_W-1:0]         inflight_o,
    output logic                     err_o
);
    logic [CNT_W-1:0] inflight_q, inflight_d, drop_q, drop_d, fifo_count;
    logic [OPERAND_WIDTH-1:0] fifo_data;
    logic err_q, err_d, fifo_full, fifo_valid;
    logic done_ok, push_req, bypass, push, pop;
    vpu_resbuf_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .wdata_i (result_i),
        .rdata_o (fifo_data),
        .count_o (fifo_count),
        .full_o  (fifo_full)
    );
    always_comb begin
        done_ok       = done_i && inflight_q != '0;
        // Registered occupancy only: a pop this cycle returns its credit next cycle.
        issue_ready_o = !flush_i && ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W + 1)'(DEPTH);
        issue_o       = issue_req_i && issue_ready_o;
        push_req      = done_ok && drop_q == '0 && !flush_i;
        fifo_valid    = fifo_count != '0;
`ifdef VPU_FP_RESBUF_BYPASS_EN
        bypass        = push_req && !fifo_valid && ready_i;
        valid_o       = fifo_valid || bypass;
        data_o        = bypass ? result_i : fifo_data;
`else
        bypass        = 1'b0;
        valid_o       = fifo_valid;
        data_o        = fifo_data;
`endif
        push          = push_req && !bypass;
        pop           = fifo_valid && ready_i;
        inflight_d    = inflight_q + CNT_W'(issue_o) - CNT_W'(done_ok);
        drop_d        = flush_i ? inflight_q - CNT_W'(done_ok)
                                : drop_q - CNT_W'(done_ok && drop_q != '0);
        err_d         = err_q || (done_i && inflight_q == '0) || (push && fifo_full && !pop);
        count_o       = fifo_count;
        inflight_o    = inflight_q;
        err_o         = err_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_vpu_fp_result_buffer.sv
// tb_vpu_fp_result_buffer: random and directed stimulus against a queue-based model, DEPTH=4.
module tb_vpu_fp_result_buffer;
    import vpu_pkg::*;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int LAT = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic issue_req_i = 1'b0, done_i = 1'b0, ready_i = 1'b0, flush_i = 1'b0;
    logic [OPERAND_WIDTH-1:0] result_i = '0;
    logic issue_ready_o, issue_o, valid_o, err_o;
    logic [OPERAND_WIDTH-1:0] data_o;
    logic [CNT_W-1:0] count_o, inflight_o;

    vpu_fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_req_i   (issue_req_i),
        .issue_ready_o (issue_ready_o),
        .issue_o       (issue_o),
        .done_i        (done_i),
        .result_i      (result_i),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .ready_i       (ready_i),
        .flush_i       (flush_i),
        .count_o       (count_o),
        .inflight_o    (inflight_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [OPERAND_WIDTH-1:0] mq[$];
    logic [OPERAND_WIDTH-1:0] dat_q[$];
    int due_q[$];
    int infl = 0, drop = 0, cyc = 0;
    bit err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of stimulus; the modelled exp core returns each issue LAT cycles later.
    task automatic step(input bit req, input bit rdy, input bit fl, input bit spur,
                        input logic [OPERAND_WIDTH-1:0] idata);
        bit dn, ok, keep, byp, e_rdy, e_iss, e_val;
        logic [OPERAND_WIDTH-1:0] res, e_dat;
        @(negedge clk);
        dn  = 1'b0;
        res = OPERAND_WIDTH'($urandom);
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            dn  = 1'b1;
            res = dat_q.pop_front();
            void'(due_q.pop_front());
        end else if (spur && infl == 0) begin
            dn = 1'b1;
        end
        issue_req_i = req;
        ready_i     = rdy;
        flush_i     = fl;
        done_i      = dn;
        result_i    = res;
        e_rdy = !fl && (mq.size() + infl) < DEPTH;
        e_iss = req && e_rdy;
        ok    = dn && infl > 0;
        keep  = ok && !fl && drop == 0;
        byp   = 1'b0;
`ifdef VPU_FP_RESBUF_BYPASS_EN
        byp   = keep && mq.size() == 0 && rdy;
`endif
        e_val = mq.size() != 0 || byp;
        e_dat = byp ? res : (mq.size() != 0 ? mq[0] : '0);
        #1;
        check("issue_ready", 32'(issue_ready_o), 32'(e_rdy));
        check("issue", 32'(issue_o), 32'(e_iss));
        check("valid", 32'(valid_o), 32'(e_val));
        if (e_val) check("data", 32'(data_o), 32'(e_dat));
        check("count", 32'(count_o), mq.size());
        check("inflight", 32'(inflight_o), infl);
        check("err", 32'(err_o), 32'(err));
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (dn && infl == 0) err = 1'b1;
        if (ok) begin
            infl--;
            if (!fl && drop > 0) drop--;
        end
        if (keep && !byp) begin
            if (mq.size() < DEPTH) mq.push_back(res);
            else err = 1'b1;
        end
        if (fl) begin
            mq.delete();
            drop = infl;
        end
        if (e_iss) begin
            infl++;
            due_q.push_back(cyc + LAT);
            dat_q.push_back(idata);
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 1'b0, '0);
    endtask

    initial begin
        issue_req_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_issue_ready", 32'(issue_ready_o), 1);
        check("rst_issue", 32'(issue_o), 1);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_inflight", 32'(inflight_o), 0);
        check("rst_err", 32'(err_o), 0);
        issue_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h3F80);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h4000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h4040);
        idle(6, 1'b1);

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, OPERAND_WIDTH'($urandom));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, OPERAND_WIDTH'($urandom));
        idle(8, 1'b1);

        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, OPERAND_WIDTH'($urandom));
        idle(3, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, OPERAND_WIDTH'($urandom));
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h3F80);
        idle(6, 1'b1);

        step(1'b0, 1'b1, 1'b0, 1'b1, '0);
        idle(3, 1'b1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0,
                 OPERAND_WIDTH'($urandom));

        @(negedge clk);
        rst_n       = 1'b0;
        issue_req_i = 1'b0;
        done_i      = 1'b0;
        flush_i     = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 0);
        check("mid_rst_count", 32'(count_o), 0);
        check("mid_rst_inflight", 32'(inflight_o), 0);
        check("mid_rst_err", 32'(err_o), 0);
        check("mid_rst_issue_ready", 32'(issue_ready_o), 1);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
